// File: rtl/muldiv_issuer_pkg.sv
// Shared types and helpers for the multiply/divide issuer.
package muldiv_issuer_pkg;

    localparam int unsigned XLEN_W       = 64;
    localparam int unsigned DIV_ITERS_64 = 64;
    localparam int unsigned DIV_ITERS_32 = 32;
    localparam int unsigned DIV_CNT_W    = 7;

    typedef logic [XLEN_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
        OP_MUL, OP_MULW,
        OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW,
        OP_REM, OP_REMU, OP_REMW, OP_REMUW
    } decode_op_t;

    function automatic word_t sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Divide-by-zero and signed-overflow results, before W-form sign extension.
    function automatic word_t special_result(input logic is_rem, input logic dz,
                                             input word_t dividend);
        if (dz) return is_rem ? dividend : {XLEN_W{1'b1}};
        return is_rem ? {XLEN_W{1'b0}} : dividend;
    endfunction

endpackage

// File: rtl/muldiv_issuer_divider_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
import muldiv_issuer_pkg::*;

module divider_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_kill,
    input  logic        i_start,
    input  logic        i_w32,
    input  logic [63:0] i_dividend,
    input  logic [63:0] i_divisor,
    output logic [63:0] o_quot,
    output logic [63:0] o_rem,
    output logic        o_done
);

    word_t                r_quot;
    word_t                r_rem;
    word_t                r_div;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic                 r_busy;
    logic                 r_done;

    logic [64:0] w_shift;
    logic [64:0] w_diff;

    assign w_shift = {r_rem, r_quot[63]};
    assign w_diff  = w_shift - {1'b0, r_div};

    // 32-bit divides pre-shift the dividend so quotient bits still enter at the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_kill) begin
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_busy <= 1'b1;
                r_rem  <= '0;
                r_div  <= i_divisor;
                r_quot <= i_w32 ? {i_dividend[31:0], 32'b0} : i_dividend;
                r_cnt  <= i_w32 ? DIV_CNT_W'(DIV_ITERS_32 - 1) : DIV_CNT_W'(DIV_ITERS_64 - 1);
            end else if (r_busy) begin
                if (!w_diff[64]) begin
                    r_rem  <= w_diff[63:0];
                    r_quot <= {r_quot[62:0], 1'b1};
                end else begin
                    r_rem  <= w_shift[63:0];
                    r_quot <= {r_quot[62:0], 1'b0};
                end
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - DIV_CNT_W'(1);
                end
            end
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_done = r_done;

endmodule

// File: rtl/muldiv_issuer.sv
// Multi-cycle RV64M multiply/divide unit with valid/ready handshake.
// Optional MULDIV_DIV_EARLY_OUT_EN: divide-by-zero/overflow complete one cycle after accept.
import muldiv_issuer_pkg::*;

module muldiv_issuer #(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned XLEN        = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  decode_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] c
);

    localparam int unsigned MCNT_W = 8;

    muldiv_state_t     r_state;
    logic [MCNT_W-1:0] r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    word_t             r_c;
    word_t             r_a;
    word_t             r_b;
    word_t             r_sa;
    logic              r_w;
    logic              r_rem_sel;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic              r_ovf;

    logic  w_is_mul, w_is_div, w_is_w, w_signed, w_is_rem;
    logic  w_neg_a, w_neg_b, w_dz, w_ovf, w_early, w_accept, w_div_start;
    word_t w_sa, w_sb, w_abs_a, w_abs_b;
    word_t w_quot, w_rem, w_q, w_r, w_div_res, w_div_c, w_prod, w_mul_c, w_early_c;
    logic  [31:0] w_prodw;
    logic  w_div_done;

    // Decode of the incoming op.
    assign w_is_mul = (op == OP_MUL) || (op == OP_MULW);
    assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU)  || (op == OP_DIVW) || (op == OP_DIVUW) ||
                      (op == OP_REM)  || (op == OP_REMU)  || (op == OP_REMW) || (op == OP_REMUW);
    assign w_is_w   = (op == OP_MULW) || (op == OP_DIVW) || (op == OP_DIVUW) ||
                      (op == OP_REMW) || (op == OP_REMUW);
    assign w_signed = (op == OP_DIV) || (op == OP_DIVW) || (op == OP_REM) || (op == OP_REMW);
    assign w_is_rem = (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);

    // Operands extended to 64 bits at op width, then reduced to magnitudes.
    assign w_sa    = w_is_w ? (w_signed ? sext32(a[31:0]) : {32'b0, a[31:0]}) : word_t'(a);
    assign w_sb    = w_is_w ? (w_signed ? sext32(b[31:0]) : {32'b0, b[31:0]}) : word_t'(b);
    assign w_neg_a = w_signed && w_sa[63];
    assign w_neg_b = w_signed && w_sb[63];
    assign w_abs_a = w_neg_a ? -w_sa : w_sa;
    assign w_abs_b = w_neg_b ? -w_sb : w_sb;
    assign w_dz    = (w_sb == '0);
    assign w_ovf   = w_signed && (w_sb == '1) &&
                     (w_sa == (w_is_w ? sext32(32'h8000_0000) : {1'b1, 63'b0}));

`ifdef MULDIV_DIV_EARLY_OUT_EN
    assign w_early = w_is_div && (w_dz || w_ovf);
`else
    assign w_early = 1'b0;
`endif

    assign w_accept    = in_valid && r_in_ready && !flush && (w_is_mul || w_is_div);
    assign w_div_start = w_accept && w_is_div && !w_early;
    assign w_early_c   = w_is_w ? sext32(special_result(w_is_rem, w_dz, w_sa)[31:0])
                                : special_result(w_is_rem, w_dz, w_sa);

    divider_iter u_div (
        .clk        (clk),
        .reset      (reset),
        .i_kill     (flush),
        .i_start    (w_div_start),
        .i_w32      (w_is_w),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_done     (w_div_done)
    );

    // Sign fixup and special cases applied to the divider's magnitudes.
    assign w_q       = r_neg_q ? -w_quot : w_quot;
    assign w_r       = r_neg_r ? -w_rem  : w_rem;
    assign w_div_res = (r_dz || r_ovf) ? special_result(r_rem_sel, r_dz, r_sa)
                                       : (r_rem_sel ? w_r : w_q);
    assign w_div_c   = r_w ? sext32(w_div_res[31:0]) : w_div_res;

    assign w_prod  = r_a * r_b;
    assign w_prodw = r_a[31:0] * r_b[31:0];
    assign w_mul_c = r_w ? sext32(w_prodw) : w_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sa        <= '0;
            r_w         <= 1'b0;
            r_rem_sel   <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_sa       <= w_sa;
                        r_w        <= w_is_w;
                        r_rem_sel  <= w_is_rem;
                        r_neg_q    <= w_neg_a ^ w_neg_b;
                        r_neg_r    <= w_neg_a;
                        r_dz       <= w_dz;
                        r_ovf      <= w_ovf;
                        r_in_ready <= 1'b0;
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                            r_cnt   <= MCNT_W'(MUL_LATENCY - 1);
                        end else if (w_early) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_c         <= w_early_c;
                        end else begin
                            r_state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_c         <= w_mul_c;
                    end else begin
                        r_cnt <= r_cnt - MCNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_c         <= w_div_c;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign c         = r_c;

endmodule

// File: tb/tb_muldiv_issuer.sv
// Randomized self-checking bench for muldiv_issuer against an arithmetic reference model.
import muldiv_issuer_pkg::*;

module tb_muldiv_issuer;

    localparam int unsigned LAT = 3;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    decode_op_t  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] c;

    int n_checks;
    int n_errors;

    muldiv_issuer #(.MUL_LATENCY(LAT), .XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Reference results straight from the RV64M rules using native arithmetic.
    function automatic logic [63:0] ref_result(input decode_op_t o, input logic [63:0] x,
                                               input logic [63:0] y);
        longint          sx64, sy64;
        int              sx32, sy32;
        int unsigned     ux32, uy32;
        logic [31:0]     r32;
        logic [63:0]     r64;
        sx64 = x; sy64 = y;
        sx32 = x[31:0]; sy32 = y[31:0];
        ux32 = x[31:0]; uy32 = y[31:0];
        r64 = '0; r32 = '0;
        case (o)
            OP_MUL:  r64 = x * y;
            OP_MULW: begin r32 = x[31:0] * y[31:0]; r64 = sx(r32); end
            OP_DIV:  if (y == 0) r64 = '1;
                     else if (sx64 == 64'sh8000_0000_0000_0000 && sy64 == -1) r64 = x;
                     else r64 = sx64 / sy64;
            OP_DIVU: r64 = (y == 0) ? '1 : x / y;
            OP_REM:  if (y == 0) r64 = x;
                     else if (sx64 == 64'sh8000_0000_0000_0000 && sy64 == -1) r64 = '0;
                     else r64 = sx64 % sy64;
            OP_REMU: r64 = (y == 0) ? x : x % y;
            OP_DIVW: begin
                if (sy32 == 0) r32 = '1;
                else if (sx32 == 32'sh8000_0000 && sy32 == -1) r32 = x[31:0];
                else r32 = sx32 / sy32;
                r64 = sx(r32);
            end
            OP_DIVUW: begin r32 = (uy32 == 0) ? '1 : ux32 / uy32; r64 = sx(r32); end
            OP_REMW: begin
                if (sy32 == 0) r32 = x[31:0];
                else if (sx32 == 32'sh8000_0000 && sy32 == -1) r32 = '0;
                else r32 = sx32 % sy32;
                r64 = sx(r32);
            end
            OP_REMUW: begin r32 = (uy32 == 0) ? ux32 : ux32 % uy32; r64 = sx(r32); end
            default: r64 = '0;
        endcase
        return r64;
    endfunction

    function automatic int exp_lat(input decode_op_t o, input logic [63:0] x, input logic [63:0] y);
        logic wform, sgn, special;
        if (o == OP_MUL || o == OP_MULW) return LAT;
        wform = (o == OP_DIVW || o == OP_DIVUW || o == OP_REMW || o == OP_REMUW);
        sgn   = (o == OP_DIV || o == OP_DIVW || o == OP_REM || o == OP_REMW);
        special = wform ? (y[31:0] == 0 || (sgn && x[31:0] == 32'h8000_0000 && y[31:0] == '1))
                        : (y == 0 || (sgn && x == 64'h8000_0000_0000_0000 && y == '1));
`ifdef MULDIV_DIV_EARLY_OUT_EN
        if (special) return 1;
`else
        if (special) return wform ? 33 : 65;
`endif
        return wform ? 33 : 65;
    endfunction

    function automatic logic [63:0] rand_word();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = '0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'hFFFF_FFFF_8000_0000;
            4: begin v = 64'($urandom_range(1, 40)); if ($urandom_range(0, 1) == 1) v = -v; end
            5: v = sx($urandom);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Issue one op, check busy/latency/result, optionally stall the consumer.
    task automatic run_op(input string tag, input decode_op_t o, input logic [63:0] x,
                          input logic [63:0] y, input int hold);
        logic [63:0] e;
        int el, lat;
        logic seen_ready;
        e = ref_result(o, x, y);
        el = exp_lat(o, x, y);
        @(negedge clk);
        chk({tag, "_rdy_idle"}, 64'(in_ready), 64'd1);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_rdy_acc"}, 64'(in_ready), 64'd0);
        chk({tag, "_vld_early"}, 64'(out_valid), 64'd0);
        lat = 0;
        seen_ready = 1'b0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) seen_ready = 1'b1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_busy"}, 64'(seen_ready), 64'd0);
        chk({tag, "_c"}, c, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_c"}, c, e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic start_and_wait(input decode_op_t o, input logic [63:0] x, input logic [63:0] y);
        int n;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("wait_valid", 64'(out_valid), 64'd1);
    endtask

    decode_op_t md_ops[10] = '{OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_DIVW,
                               OP_DIVUW, OP_REM, OP_REMU, OP_REMW, OP_REMUW};

    initial begin
        int seen;
        n_checks = 0; n_errors = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_ADD; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        chk("rst_c", c, 64'd0);
        reset = 1'b0;

        run_op("mul_neg", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 4);
        chk("mul_neg_const", ref_result(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("divw_ovf", OP_DIVW, 64'h0000_0000_8000_0000, '1, 0);
        run_op("remw_ovf", OP_REMW, 64'h0000_0000_8000_0000, '1, 1);
        run_op("divu_z", OP_DIVU, 64'd100, 64'd0, 0);
        run_op("remu_z", OP_REMU, 64'd100, 64'd0, 0);
        run_op("rem_neg", OP_REM, -64'sd7, 64'd2, 0);
        run_op("div_neg", OP_DIV, -64'sd20, 64'd3, 2);
        run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1, 0);
        run_op("remuw_z", OP_REMUW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 0);

        // Flush mid-divide: no result may appear.
        @(negedge clk);
        op = OP_DIV; a = 64'd1000; b = 64'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_rdy", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_vld", 64'(seen), 64'd0);
        run_op("mulw_post", OP_MULW, 64'h1_0000_0002, 64'd3, 0);
        chk("mulw_const", ref_result(OP_MULW, 64'h1_0000_0002, 64'd3), 64'd6);

        // Flush beats a same-cycle accept.
        @(negedge clk);
        op = OP_MUL; a = 64'd5; b = 64'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_rdy", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_acc_vld", 64'(seen), 64'd0);

        // Flush in DONE together with out_ready discards the result.
        start_and_wait(OP_MUL, 64'd9, 64'd9);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_done_vld", 64'(out_valid), 64'd0);
        chk("flush_done_rdy", 64'(in_ready), 64'd1);

        // Reset while holding a result, then a non-muldiv op is ignored.
        start_and_wait(OP_DIVU, 64'd50, 64'd5);
        chk("pre_rst_c", c, 64'd10);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_done_vld", 64'(out_valid), 64'd0);
        chk("rst_done_c", c, 64'd0);
        chk("rst_done_rdy", 64'(in_ready), 64'd1);
        op = OP_ADD; a = 64'd1; b = 64'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("add_ignored_rdy", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("add_ignored_vld", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            run_op("rnd", md_ops[$urandom_range(0, 9)], rand_word(), rand_word(),
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_issuer.md
Name: muldiv_issuer

Overview:
Multi-cycle producer of c_mul/c_div for the execute stage. Accepts a MUL/DIV/REM-class op plus operands from the pipeline, runs an iterative divider or a latency-counted multiplier, and returns a 64-bit RV64M-correct result through a valid/ready handshake. The execute-stage stall logic holds the instruction while in_ready/out_valid indicate the unit is busy.

Parameters:
MUL_LATENCY, 3, cycles from accept to out_valid for MUL/MULW (must be >= 1).
XLEN, 64, operand/result width (fixed 64 for this core; parameter documents intent).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
flush  input  1  cancel in-flight op (pipeline redirect)
in_valid  input  1  op and operands valid
in_ready  output  1  unit can accept (state IDLE)
op  input  decode_op_t  one of MUL, MULW, DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
a  input  64  rs1 value
b  input  64  rs2 value
out_valid  output  1  result available
out_ready  input  1  consumer takes result this cycle
c  output  64  result; consumed as c_mul or c_div by the execute result selection

Behaviour:
- Clock clk; reset is synchronous and active-high: on posedge clk with reset=1 -> state IDLE, counters 0, out_valid=0, c=0, in_ready=1 next cycle.
- States: IDLE, MUL, DIV, DONE.
- IDLE: in_ready=1. Accept when in_valid&&in_ready (cycle T): latch op, a, b. MUL/MULW -> MUL with cnt=MUL_LATENCY-1; otherwise DIV with cnt=N-1, N=64 (64-bit) or 32 (W forms). A non-muldiv op with in_valid is ignored (stays IDLE).
- MUL: cnt decrements; at cnt==0 -> DONE. out_valid first high at T+MUL_LATENCY.
- DIV: radix-2 restoring, one quotient bit per cycle on absolute values; at cnt==0 apply signs -> DONE. out_valid first high at T+N+1 (65 or 33).
- DONE: out_valid=1, c stable; on out_ready -> IDLE (in_ready high the following cycle, no same-cycle re-accept).
- Arithmetic: MUL = low 64 of a*b; MULW = sext32(low32(a)*low32(b)). W divides use a[31:0], b[31:0], result sext32. Signed ops: quotient negative iff signs differ; remainder takes dividend sign.
- Divide-by-zero: quotient = all ones (-1 at op width); remainder = dividend. Overflow (signed min / -1): quotient = dividend, remainder = 0. Results sign-extended for W forms.
- flush: any state -> IDLE next cycle, out_valid=0; flush beats a same-cycle accept (nothing captured). flush in DONE with out_ready=1: result discarded.
- reset mid-operation: identical to flush plus c cleared.
- out_valid never deasserts without out_ready, flush, or reset; c unchanged while out_valid=1.

Optional Feature:
MULDIV_DIV_EARLY_OUT_EN. Defined: divide-by-zero and signed overflow detected at accept; unit goes straight to DONE, out_valid at T+1. Undefined: these cases run the full N iterations; result values are identical either way.

Decomposition:
- Package pipes: muldiv_state_t enum (IDLE, MUL, DIV, DONE); helper constant DIV_ITERS_64=64, DIV_ITERS_32=32; reuse existing decode_op_t.
- Package common: word_t for a/b/c.
- Sub-module divider_iter: start/width-select input, absolute-value dividend/divisor, per-cycle restoring step, quotient/remainder outputs, done flag; sign fixup and special cases stay in muldiv_issuer.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), MUL_LATENCY=3 -> out_valid at T+3, c=0xFFFF_FFFF_FFFF_FFEB; out_ready=0 for 4 cycles -> c and out_valid held.
- DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> c=0xFFFF_FFFF_8000_0000; REMW same operands -> c=0; out_valid at T+33 (T+1 with MULDIV_DIV_EARLY_OUT_EN).
- DIVU a=100, b=0 -> c=0xFFFF_FFFF_FFFF_FFFF; REMU a=100, b=0 -> c=100; REM a=-7, b=2 -> c=-1.
- DIV a=-20, b=3 -> c=-6 at exactly T+65; in_ready=0 throughout T+1..T+65.
- flush asserted at T+10 of a DIV -> IDLE at T+11, out_valid never rises; new MULW a=0x1_0000_0002, b=3 accepted -> c=6.
- reset asserted in DONE with out_valid=1 -> next cycle out_valid=0, c=0, in_ready=1; in_valid with op=ADD -> no accept.
